// File: rtl/fight_pkg.sv
// Shared encodings for the fighting-game match sequencer: FSM states, winner codes,
// player action codes and small scoring helpers.
package fight_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned WIN_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_INIT      = 3'd1,
    ST_COUNTDOWN = 3'd2,
    ST_FIGHT     = 3'd3,
    ST_ROUND_END = 3'd4,
    ST_MATCH_END = 3'd5
  } state_e;

  localparam logic [WIN_W-1:0] WIN_NONE = 2'b00;
  localparam logic [WIN_W-1:0] WIN_P1   = 2'b01;
  localparam logic [WIN_W-1:0] WIN_P2   = 2'b10;
  localparam logic [WIN_W-1:0] WIN_DRAW = 2'b11;

  typedef enum logic [2:0] {
    KICK  = 3'd0,
    PUNCH = 3'd1,
    SABR  = 3'd2,
    JUMP  = 3'd3,
    LEFT  = 3'd4,
    RIGHT = 3'd5
  } action_e;

  // Knock-out outcome wins over the lives comparison used on timeout.
  function automatic logic [WIN_W-1:0] round_result(input logic l1_zero, input logic l2_zero,
                                                    input logic p1_more, input logic p2_more);
    logic [WIN_W-1:0] res;
    if (l1_zero && l2_zero)  res = WIN_DRAW;
    else if (l1_zero)        res = WIN_P2;
    else if (l2_zero)        res = WIN_P1;
    else if (p1_more)        res = WIN_P1;
    else if (p2_more)        res = WIN_P2;
    else                     res = WIN_DRAW;
    return res;
  endfunction

  function automatic logic [WIN_W-1:0] sat_inc(input logic [WIN_W-1:0] w);
    return (w == '1) ? w : w + WIN_W'(1);
  endfunction

endpackage

// File: rtl/fight_tick_gen.sv
// Game-tick divider: counts 0..TICK_DIV-1 while running and pulses on the last count.
module fight_tick_gen #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)    cnt_d = '0;
    else if (run) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = run && (cnt_q == LAST);

endmodule

// File: rtl/fight_match_ctrl.sv
// Match sequencer: countdown -> fight -> round end, round scoring and match winner.
// Define FIGHT_PAUSE_EN to build the in-fight pause (freezes timer, drops control).
module fight_match_ctrl
  import fight_pkg::*;
#(
  parameter int unsigned TICK_DIV        = 50_000_000,
  parameter int unsigned COUNTDOWN_TICKS = 3,
  parameter int unsigned ROUND_TICKS     = 60,
  parameter int unsigned HOLD_TICKS      = 2,
  parameter int unsigned ROUNDS_TO_WIN   = 2,
  parameter int unsigned MAX_ROUNDS      = 5,
  parameter int unsigned LIVES_W         = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  input  logic [LIVES_W-1:0] lives1,
  input  logic [LIVES_W-1:0] lives2,
  output logic               core_init,
  output logic               control,
  output logic [6:0]         round_time,
  output logic [1:0]         wins1,
  output logic [1:0]         wins2,
  output logic [1:0]         winner,
  output logic               match_done,
  output logic [2:0]         state
);

  localparam int unsigned RT_W  = 7;
  localparam int unsigned PH_W  = 3;
  localparam int unsigned RND_W = 3;

  state_e state_q, state_d;

  logic tick, run_c, clear_c, pause_c, freeze_c;
  logic ko_c, timeout_c, match_over_c;
  logic [WIN_W-1:0] result_c;

  logic [PH_W-1:0]  phase_q, phase_d;
  logic [RND_W-1:0] round_q, round_d;
  logic [RT_W-1:0]  round_time_q, round_time_d;
  logic [WIN_W-1:0] wins1_q, wins1_d, wins2_q, wins2_d, winner_q, winner_d;
  logic core_init_q, core_init_d, control_q, control_d, match_done_q, match_done_d;

`ifdef FIGHT_PAUSE_EN
  assign pause_c = pause;
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign pause_c      = 1'b0;
`endif

  assign freeze_c     = pause_c && (state_q == ST_FIGHT);
  assign run_c        = ((state_q == ST_COUNTDOWN) || (state_q == ST_FIGHT) ||
                         (state_q == ST_ROUND_END)) && !freeze_c;
  assign clear_c      = (state_d != state_q);
  assign ko_c         = (lives1 == '0) || (lives2 == '0);
  assign timeout_c    = tick && (round_time_q == RT_W'(1));
  assign result_c     = round_result(lives1 == '0, lives2 == '0, lives1 > lives2, lives2 > lives1);
  assign match_over_c = (wins1_q == WIN_W'(ROUNDS_TO_WIN)) || (wins2_q == WIN_W'(ROUNDS_TO_WIN)) ||
                        (round_q == RND_W'(MAX_ROUNDS));

  fight_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (clear_c),
    .run   (run_c),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (start) state_d = ST_INIT;
      ST_INIT:      state_d = ST_COUNTDOWN;
      ST_COUNTDOWN: if (tick && (phase_q == PH_W'(1))) state_d = ST_FIGHT;
      ST_FIGHT:     if (ko_c || timeout_c) state_d = ST_ROUND_END;
      ST_ROUND_END: if (tick && (phase_q == PH_W'(1)))
                      state_d = match_over_c ? ST_MATCH_END : ST_INIT;
      ST_MATCH_END: if (start) state_d = ST_INIT;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs, all keyed off the current/next state.
  always_comb begin
    phase_d      = phase_q;
    round_d      = round_q;
    round_time_d = round_time_q;
    wins1_d      = wins1_q;
    wins2_d      = wins2_q;
    winner_d     = winner_q;

    if (((state_q == ST_IDLE) || (state_q == ST_MATCH_END)) && start) begin
      round_d  = '0;
      wins1_d  = '0;
      wins2_d  = '0;
      winner_d = WIN_NONE;
    end
    if (state_q == ST_INIT) begin
      round_d = round_q + RND_W'(1);
      phase_d = PH_W'(COUNTDOWN_TICKS);
    end
    if (tick && ((state_q == ST_COUNTDOWN) || (state_q == ST_ROUND_END)))
      phase_d = phase_q - PH_W'(1);
    if ((state_q == ST_COUNTDOWN) && (state_d == ST_FIGHT))
      round_time_d = RT_W'(ROUND_TICKS);
    if (state_q == ST_FIGHT) begin
      if (tick) round_time_d = round_time_q - RT_W'(1);
      if (state_d == ST_ROUND_END) begin
        phase_d = PH_W'(HOLD_TICKS);
        if (result_c == WIN_P1) wins1_d = sat_inc(wins1_q);
        if (result_c == WIN_P2) wins2_d = sat_inc(wins2_q);
      end
    end
    if ((state_q == ST_ROUND_END) && (state_d == ST_MATCH_END)) begin
      if (wins1_q > wins2_q)      winner_d = WIN_P1;
      else if (wins2_q > wins1_q) winner_d = WIN_P2;
      else                        winner_d = WIN_DRAW;
    end

    core_init_d  = (state_d == ST_INIT);
    control_d    = (state_d == ST_FIGHT) && !pause_c;
    match_done_d = (state_d == ST_MATCH_END);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q      <= '0;
      round_q      <= '0;
      round_time_q <= '0;
      wins1_q      <= '0;
      wins2_q      <= '0;
      winner_q     <= WIN_NONE;
      core_init_q  <= 1'b0;
      control_q    <= 1'b0;
      match_done_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      round_q      <= round_d;
      round_time_q <= round_time_d;
      wins1_q      <= wins1_d;
      wins2_q      <= wins2_d;
      winner_q     <= winner_d;
      core_init_q  <= core_init_d;
      control_q    <= control_d;
      match_done_q <= match_done_d;
    end
  end

  assign core_init  = core_init_q;
  assign control    = control_q;
  assign round_time = round_time_q;
  assign wins1      = wins1_q;
  assign wins2      = wins2_q;
  assign winner     = winner_q;
  assign match_done = match_done_q;
  assign state      = 3'(state_q);

endmodule

// File: tb/tb_fight_match_ctrl.sv
// Scoreboard bench for fight_match_ctrl: a round-level model predicts event cycles and
// scores; a monitor pops and compares whenever the DUT shows an event.
module tb_fight_match_ctrl;

  localparam int TD  = 4;
  localparam int CT  = 3;
  localparam int RT  = 5;
  localparam int HT  = 2;
  localparam int RTW = 2;
  localparam int MR  = 5;

  localparam int EV_INIT  = 0;
  localparam int EV_FIGHT = 1;
  localparam int EV_RE    = 2;
  localparam int EV_END   = 3;

`ifdef FIGHT_PAUSE_EN
  localparam bit PAUSE_IGNORED = 1'b0;
`else
  localparam bit PAUSE_IGNORED = 1'b1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [2:0] lives1 = 3'd3;
  logic [2:0] lives2 = 3'd3;
  logic       core_init, control, match_done;
  logic [6:0] round_time;
  logic [1:0] wins1, wins2, winner;
  logic [2:0] state;

  typedef struct {
    int kind;
    int cyc;
    int a;
    int b;
  } ev_t;

  ev_t sb[$];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_errors = 0;
  bit  mon_en = 1'b0;
  logic       prev_control = 1'b0;
  logic       prev_done = 1'b0;
  logic [2:0] prev_state = 3'd0;

  fight_match_ctrl #(
    .TICK_DIV(TD), .COUNTDOWN_TICKS(CT), .ROUND_TICKS(RT), .HOLD_TICKS(HT),
    .ROUNDS_TO_WIN(RTW), .MAX_ROUNDS(MR), .LIVES_W(3)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause),
    .lives1(lives1), .lives2(lives2),
    .core_init(core_init), .control(control), .round_time(round_time),
    .wins1(wins1), .wins2(wins2), .winner(winner),
    .match_done(match_done), .state(state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic push_ev(input int kind, input int c, input int a, input int b);
    ev_t e;
    e.kind = kind; e.cyc = c; e.a = a; e.b = b;
    sb.push_back(e);
  endtask

  task automatic expect_ev(input int kind, input int a, input int b);
    ev_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_event cyc=%0d got=kind%0d want=none", cyc, kind);
      return;
    end
    e = sb.pop_front();
    check("ev_kind", kind, e.kind);
    check("ev_cycle", cyc, e.cyc);
    check("ev_val_a", a, e.a);
    check("ev_val_b", b, e.b);
  endtask

  // Monitor: spec-level invariants every cycle plus event-driven scoreboard pops.
  always @(negedge clk) begin
    if (mon_en) begin
      check("control_only_in_fight", int'(control), int'(state == 3'd3));
      check("init_only_in_init", int'(core_init), int'(state == 3'd1));
      check("done_only_in_match_end", int'(match_done), int'(state == 3'd5));
      if (core_init) expect_ev(EV_INIT, int'(wins1), int'(wins2));
      if (control && !prev_control) expect_ev(EV_FIGHT, int'(round_time), int'(state));
      if (state == 3'd4 && prev_state != 3'd4) expect_ev(EV_RE, int'(wins1), int'(wins2));
      if (match_done && !prev_done) expect_ev(EV_END, int'(winner), int'(state));
    end
    prev_control = control;
    prev_state   = state;
    prev_done    = match_done;
  end

  task automatic wait_cyc(input int t);
    if (cyc > t) check("schedule_late", cyc, t);
    while (cyc < t) @(negedge clk);
  endtask

  // One round: pick stimulus, predict from the rules, push events, then drive lives.
  task automatic play_round(input int mode, input int rnd, input bit first,
                            inout int c_init, inout int w1, inout int w2, output bit over);
    bit ko;
    int k, n1, n2, kv1, kv2, c_fight, c_re, res, win;
    ko = 1'b0; k = 0; n1 = 3; n2 = 3; kv1 = 3; kv2 = 3;
    case (mode)
      0: begin
        if (rnd == 1)      begin ko = 1'b1; k = 2; kv1 = 3; kv2 = 0; end
        else if (rnd == 2) begin n1 = 2; n2 = 2; end
        else               begin n1 = 3; n2 = 2; end
      end
      1: begin
        ko = 1'b1; k = RT * TD - 1; n1 = 4; n2 = 5; kv1 = 0; kv2 = 0;
      end
      default: begin
        n1  = $urandom_range(1, 7);
        n2  = $urandom_range(1, 7);
        ko  = ($urandom_range(0, 2) != 0);
        k   = $urandom_range(0, RT * TD - 1);
        kv1 = $urandom_range(0, 3);
        kv2 = $urandom_range(0, 3);
        if (kv1 != 0 && kv2 != 0) begin
          if ($urandom_range(0, 1) == 1) kv1 = 0;
          else                           kv2 = 0;
        end
      end
    endcase

    c_fight = c_init + 1 + CT * TD;
    c_re    = ko ? c_fight + k + 1 : c_fight + RT * TD;
    if (ko) res = (kv1 == 0 && kv2 == 0) ? 3 : ((kv1 == 0) ? 2 : 1);
    else    res = (n1 > n2) ? 1 : ((n2 > n1) ? 2 : 3);

    push_ev(EV_INIT, c_init, w1, w2);
    if (res == 1 && w1 < 3) w1++;
    if (res == 2 && w2 < 3) w2++;
    push_ev(EV_FIGHT, c_fight, RT, 3);
    push_ev(EV_RE, c_re, w1, w2);
    over = (w1 == RTW) || (w2 == RTW) || (rnd == MR);
    if (over) begin
      win = (w1 > w2) ? 1 : ((w2 > w1) ? 2 : 3);
      push_ev(EV_END, c_re + HT * TD, win, 5);
    end

    wait_cyc(c_init - 1);
    if (first) start = 1'b1;
    lives1 = 3'(n1);
    lives2 = 3'(n2);
    wait_cyc(c_init);
    start = 1'b0;
    if (ko) begin
      wait_cyc(c_fight + k);
      lives1 = 3'(kv1);
      lives2 = 3'(kv2);
    end
    wait_cyc(c_re);
    c_init = c_re + HT * TD;
  endtask

  task automatic run_match(input int mode);
    int  c_init, w1, w2;
    bit  over;
    c_init = cyc + 1;
    w1 = 0;
    w2 = 0;
    over = 1'b0;
    for (int rnd = 1; rnd <= MR; rnd++) begin
      play_round(mode, rnd, rnd == 1, c_init, w1, w2, over);
      if (over) break;
    end
    wait_cyc(c_init + 2);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, int'(state), 0);
    check({tag, "_control"}, int'(control), 0);
    check({tag, "_core_init"}, int'(core_init), 0);
    check({tag, "_match_done"}, int'(match_done), 0);
    check({tag, "_round_time"}, int'(round_time), 0);
    check({tag, "_wins1"}, int'(wins1), 0);
    check({tag, "_wins2"}, int'(wins2), 0);
    check({tag, "_winner"}, int'(winner), 0);
  endtask

  initial begin
    int c_init, w1, w2, c_fight;
    bit over;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    run_match(0);
    run_match(1);
    for (int m = 0; m < 6; m++) begin
      pause = PAUSE_IGNORED ? 1'($urandom_range(0, 1)) : 1'b0;
      run_match(2);
    end
    pause = 1'b0;

    // Reset landing on the same edge as a knock-out: no scoring, back to IDLE.
    c_init = cyc + 1; w1 = 0; w2 = 0;
    play_round(0, 1, 1'b1, c_init, w1, w2, over);
    c_fight = c_init + 1 + CT * TD;
    push_ev(EV_INIT, c_init, w1, w2);
    push_ev(EV_FIGHT, c_fight, RT, 3);
    wait_cyc(c_init - 1);
    lives1 = 3'd3; lives2 = 3'd3;
    wait_cyc(c_fight + 3);
    lives2 = 3'd0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_all_zero("midreset");
    lives2 = 3'd3;
    repeat (2) @(negedge clk);

`ifdef FIGHT_PAUSE_EN
    c_init = cyc + 1;
    c_fight = c_init + 1 + CT * TD;
    push_ev(EV_INIT, c_init, 0, 0);
    push_ev(EV_FIGHT, c_fight, RT, 3);
    start = 1'b1;
    wait_cyc(c_init);
    start = 1'b0;
    wait_cyc(c_fight + 2);
    mon_en = 1'b0;
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("pause_control", int'(control), 0);
      check("pause_round_time", int'(round_time), RT);
    end
    pause = 1'b0;
    @(negedge clk);
    check("resume_control", int'(control), 1);
    check("resume_round_time", int'(round_time), RT);
    @(negedge clk);
    check("resume_tick", int'(round_time), RT - 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
`endif

    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
